// File: rtl/exec_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// whole-pipe freezes on data-memory backpressure, with saturating event counters.
module exec_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic             uses_rs1_d,
    input  logic             uses_rs2_d,
    input  logic [4:0]       rd_x,
    input  logic             memread_x,
    input  logic             regwrite_x,
    input  logic             branch_taken_x,
    input  logic             mem_busy_i,
    output logic             stall_f_o,
    output logic             stall_d_o,
    output logic             stall_x_o,
    output logic             bubble_x_o,
    output logic             flush_d_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_count_o,
    output logic [CNT_W-1:0] flush_count_o
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t     state, state_next;
    logic [2:0] flush_cnt, flush_cnt_next;
    logic       load_use;
    logic       stall_f, stall_d, stall_x, bubble_x, flush_d;
    logic       branch_accept;

    assign load_use = memread_x & regwrite_x & (rd_x != 5'd0) &
                      ((uses_rs1_d & (rs1_d == rd_x)) | (uses_rs2_d & (rs2_d == rd_x)));

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        stall_f        = 1'b0;
        stall_d        = 1'b0;
        stall_x        = 1'b0;
        bubble_x       = 1'b0;
        flush_d        = 1'b0;
        branch_accept  = 1'b0;
        if (mem_busy_i) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_x = 1'b1;
        end else begin
            case (state)
                LOAD_STALL: state_next = RUN;
                FLUSH: begin
                    flush_d        = 1'b1;
                    bubble_x       = 1'b1;
                    flush_cnt_next = flush_cnt - 3'd1;
                    if (flush_cnt <= 3'd1) state_next = RUN;
                end
                // RUN, and the unused encoding 3 which recovers as RUN
                default: begin
                    state_next = RUN;
                    if (branch_taken_x) begin
                        flush_d       = 1'b1;
                        bubble_x      = 1'b1;
                        branch_accept = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_next     = FLUSH;
                            flush_cnt_next = FLUSH_INIT;
                        end
                    end else if (load_use) begin
                        stall_f    = 1'b1;
                        stall_d    = 1'b1;
                        bubble_x   = 1'b1;
                        state_next = LOAD_STALL;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stall_count_o <= '0;
            flush_count_o <= '0;
        end else begin
            if (stall_d && (stall_count_o != '1)) stall_count_o <= stall_count_o + 1'b1;
            if (branch_accept && (flush_count_o != '1)) flush_count_o <= flush_count_o + 1'b1;
        end
    end

    // Outputs are forced quiet while reset is held, even if inputs still request action.
    assign stall_f_o  = reset_i & stall_f;
    assign stall_d_o  = reset_i & stall_d;
    assign stall_x_o  = reset_i & stall_x;
    assign bubble_x_o = reset_i & bubble_x;
    assign flush_d_o  = reset_i & flush_d;
    assign state_o    = state;

endmodule
